// File: rtl/i2c_burst_reg_ctrl_if.sv
// rtl/i2c_burst_reg_ctrl_if.sv - host command/buffer and byte-engine signals of the I2C burst sequencer
// slave: the sequencer itself; master: the host plus byte engine around it.
interface i2c_burst_reg_ctrl_if #(
  parameter int IDX_W = 3,
  parameter int LEN_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_rw;
  logic [7:0]       cmd_reg;
  logic [LEN_W-1:0] cmd_len;
  logic             buf_wr_en;
  logic [IDX_W-1:0] buf_wr_idx;
  logic [7:0]       buf_wr_data;
  logic [IDX_W-1:0] buf_rd_idx;
  logic [7:0]       buf_rd_data;
  logic             busy;
  logic             done;
  logic             err;
  logic [1:0]       err_code;
  logic             i2c_start;
  logic             i2c_stop;
  logic [7:0]       i2c_wr_data;
  logic [1:0]       i2c_ack;
  logic             i2c_rd_tick;
  logic [7:0]       i2c_rd_data;

  modport slave (
    input  cmd_valid, cmd_rw, cmd_reg, cmd_len,
    input  buf_wr_en, buf_wr_idx, buf_wr_data, buf_rd_idx,
    input  i2c_ack, i2c_rd_tick, i2c_rd_data,
    output cmd_ready, buf_rd_data, busy, done, err, err_code,
    output i2c_start, i2c_stop, i2c_wr_data
  );

  modport master (
    output cmd_valid, cmd_rw, cmd_reg, cmd_len,
    output buf_wr_en, buf_wr_idx, buf_wr_data, buf_rd_idx,
    output i2c_ack, i2c_rd_tick, i2c_rd_data,
    input  cmd_ready, buf_rd_data, busy, done, err, err_code,
    input  i2c_start, i2c_stop, i2c_wr_data
  );
endinterface

// File: rtl/i2c_burst_reg_ctrl.sv
// rtl/i2c_burst_reg_ctrl.sv - command-driven I2C register-burst master sequencer
// Engine strobes (start/stop/wr_data) are combinational so stop can follow the final ack or rd_tick in the same cycle.
module i2c_burst_reg_ctrl #(
  parameter logic [6:0] DEV_ADDR = 7'h68,
  parameter int         NBYTES   = 8,
  parameter int         IDX_W    = 3,
  parameter int         LEN_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  i2c_burst_reg_ctrl_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DEVW  = 3'd1;
  localparam logic [2:0] S_REGP  = 3'd2;
  localparam logic [2:0] S_WDAT  = 3'd3;
  localparam logic [2:0] S_RSTRT = 3'd4;
  localparam logic [2:0] S_RDAT  = 3'd5;
  localparam logic [2:0] S_FIN   = 3'd6;

  localparam logic [1:0] E_OK   = 2'd0;
  localparam logic [1:0] E_ADDR = 2'd1;
  localparam logic [1:0] E_DATA = 2'd2;
  localparam logic [1:0] E_RLEN = 2'd3;

  localparam int               DEPTH   = 1 << IDX_W;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(NBYTES);

  logic [2:0]       state_q, state_d;
  logic             rw_q;
  logic [7:0]       reg_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [1:0]       code_q, code_d;
  logic [7:0]       wbuf_q [DEPTH];
  logic [7:0]       rbuf_q [DEPTH];

  logic             accept;
  logic             ack_ok;
  logic             ack_nack;
  logic             last_byte;
  logic             rd_store;
  logic             start;
  logic             stop;
  logic [7:0]       wr_data;
  logic [IDX_W-1:0] idx;
  logic [LEN_W-1:0] len_clamp;

  assign accept    = bus.cmd_valid && (state_q == S_IDLE);
  assign ack_ok    = (bus.i2c_ack == 2'b11);
  assign ack_nack  = (bus.i2c_ack == 2'b10);
  assign idx       = cnt_q[IDX_W-1:0];
  assign last_byte = ((cnt_q + LEN_W'(1)) == len_q);
  assign len_clamp = (bus.cmd_len > LEN_MAX) ? LEN_MAX : bus.cmd_len;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    code_d   = code_q;
    start    = 1'b0;
    stop     = 1'b0;
    wr_data  = 8'h00;
    rd_store = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d = '0;
          // A zero-length read has nothing to fetch: report it without touching the bus.
          if (bus.cmd_rw && (len_clamp == '0)) begin
            code_d  = E_RLEN;
            state_d = S_FIN;
          end else begin
            code_d  = E_OK;
            state_d = S_DEVW;
          end
        end
      end
      S_DEVW: begin
        start   = 1'b1;
        wr_data = {DEV_ADDR, 1'b0};
        if (ack_ok) begin
          state_d = S_REGP;
        end else if (ack_nack) begin
          stop    = 1'b1;
          code_d  = E_ADDR;
          state_d = S_FIN;
        end
      end
      S_REGP: begin
        wr_data = reg_q;
        if (ack_ok) begin
          if (rw_q) begin
            start   = 1'b1;
            state_d = S_RSTRT;
          end else if (len_q == '0) begin
            stop    = 1'b1;
            state_d = S_FIN;
          end else begin
            state_d = S_WDAT;
          end
        end else if (ack_nack) begin
          stop    = 1'b1;
          code_d  = E_DATA;
          state_d = S_FIN;
        end
      end
      S_WDAT: begin
        wr_data = wbuf_q[idx];
        if (ack_ok) begin
          if (last_byte) begin
            stop    = 1'b1;
            state_d = S_FIN;
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
        end else if (ack_nack) begin
          stop    = 1'b1;
          code_d  = E_DATA;
          state_d = S_FIN;
        end
      end
      S_RSTRT: begin
        wr_data = {DEV_ADDR, 1'b1};
        if (ack_ok) begin
          state_d = S_RDAT;
        end else if (ack_nack) begin
          stop    = 1'b1;
          code_d  = E_ADDR;
          state_d = S_FIN;
        end
      end
      S_RDAT: begin
        if (bus.i2c_rd_tick) begin
          rd_store = 1'b1;
          if (last_byte) begin
            stop    = 1'b1;
            state_d = S_FIN;
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rw_q    <= 1'b0;
      reg_q   <= 8'h00;
      len_q   <= '0;
      cnt_q   <= '0;
      code_q  <= E_OK;
      for (int i = 0; i < DEPTH; i++) begin
        wbuf_q[i] <= 8'h00;
        rbuf_q[i] <= 8'h00;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      if (accept) begin
        rw_q  <= bus.cmd_rw;
        reg_q <= bus.cmd_reg;
        len_q <= len_clamp;
      end
      // The write buffer is frozen while a command may be reading it.
      if (bus.buf_wr_en && (state_q == S_IDLE)) begin
        wbuf_q[bus.buf_wr_idx] <= bus.buf_wr_data;
      end
      if (rd_store) begin
        rbuf_q[idx] <= bus.i2c_rd_data;
      end
    end
  end

  assign bus.cmd_ready   = (state_q == S_IDLE);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = (state_q == S_FIN);
  assign bus.err         = (state_q == S_FIN) && (code_q != E_OK);
  assign bus.err_code    = (state_q == S_FIN) ? code_q : E_OK;
  assign bus.buf_rd_data = rbuf_q[bus.buf_rd_idx];
  assign bus.i2c_start   = start;
  assign bus.i2c_stop    = stop;
  assign bus.i2c_wr_data = wr_data;

endmodule

// File: tb/tb_i2c_burst_reg_ctrl.sv
// tb/tb_i2c_burst_reg_ctrl.sv - randomized self-checking bench for i2c_burst_reg_ctrl
// The bench plays host and byte engine; expected byte streams come from a buffer model.
module tb_i2c_burst_reg_ctrl;

  localparam int         NB  = 8;
  localparam logic [6:0] DEV = 7'h68;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i2c_burst_reg_ctrl_if #(.IDX_W(3), .LEN_W(4)) bus ();

  i2c_burst_reg_ctrl #(.DEV_ADDR(DEV), .NBYTES(NB), .IDX_W(3), .LEN_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int vectors = 0;
  int errors  = 0;
  logic [7:0] wmodel [NB];
  logic [7:0] rmodel [NB];
  logic [7:0] rd_src [NB];
  bit         rd_fixed = 1'b0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic quiet();
    bus.cmd_valid   = 1'b0;
    bus.cmd_rw      = 1'b0;
    bus.cmd_reg     = 8'h00;
    bus.cmd_len     = 4'd0;
    bus.buf_wr_en   = 1'b0;
    bus.buf_wr_idx  = 3'd0;
    bus.buf_wr_data = 8'h00;
    bus.i2c_ack     = 2'b00;
    bus.i2c_rd_tick = 1'b0;
    bus.i2c_rd_data = 8'h00;
  endtask

  // Busy-time noise: commands and buffer writes that must be dropped, and
  // engine strobes of the kind the current phase must ignore.
  task automatic noise(input bit rd_phase);
    bus.cmd_valid   = 1'b1;
    bus.cmd_rw      = 1'($urandom);
    bus.cmd_reg     = 8'($urandom);
    bus.cmd_len     = 4'($urandom);
    bus.buf_wr_en   = 1'b1;
    bus.buf_wr_idx  = 3'($urandom);
    bus.buf_wr_data = 8'($urandom);
    bus.i2c_ack     = rd_phase ? 2'($urandom) : 2'b00;
    bus.i2c_rd_tick = rd_phase ? 1'b0 : 1'($urandom);
    bus.i2c_rd_data = 8'($urandom);
  endtask

  task automatic run_cmd(input bit rw, input logic [7:0] rg, input logic [3:0] len,
                         input int nack_at, input int abort_rd, input bit poke);
    logic [7:0] exp_b [$];
    logic [7:0] d;
    int elen, code, last;
    bit nacked, exp_stop, exp_start;
    elen   = (len > 4'(NB)) ? NB : int'(len);
    code   = (rw && elen == 0) ? 3 : 0;
    nacked = 1'b0;

    quiet();
    bus.cmd_valid = 1'b1;
    bus.cmd_rw    = rw;
    bus.cmd_reg   = rg;
    bus.cmd_len   = len;
    if (poke) begin
      bus.buf_wr_en   = 1'b1;
      bus.buf_wr_idx  = 3'($urandom);
      bus.buf_wr_data = 8'($urandom);
      wmodel[bus.buf_wr_idx] = bus.buf_wr_data;
    end
    #1;
    vectors++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL cmd_ready_at_accept: got %b expected 1", bus.cmd_ready);
    end
    @(negedge clk);

    if (!(rw && elen == 0)) begin
      exp_b.push_back({DEV, 1'b0});
      exp_b.push_back(rg);
      if (rw) exp_b.push_back({DEV, 1'b1});
      else for (int i = 0; i < elen; i++) exp_b.push_back(wmodel[i]);
    end
    last = exp_b.size() - 1;

    for (int k = 0; k < exp_b.size(); k++) begin
      repeat ($urandom_range(0, 2)) begin
        noise(1'b0); #1;
        vectors++;
        if (bus.i2c_stop !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b1) begin
          errors++; $display("FAIL idle_byte%0d: stop=%b done=%b busy=%b expected 0,0,1", k, bus.i2c_stop, bus.done, bus.busy);
        end
        if (k == 0) begin
          vectors++;
          if (bus.i2c_start !== 1'b1) begin
            errors++; $display("FAIL start_held: got %b expected 1", bus.i2c_start);
          end
        end
        @(negedge clk);
      end
      noise(1'b0);
      bus.i2c_ack = (k == nack_at) ? 2'b10 : 2'b11;
      #1;
      exp_stop  = (k == nack_at) || (!rw && k == last);
      exp_start = (k == 0) || (rw && k == 1 && k != nack_at);
      vectors++;
      if (bus.i2c_wr_data !== exp_b[k]) begin
        errors++; $display("FAIL wr_byte%0d: got %02h expected %02h", k, bus.i2c_wr_data, exp_b[k]);
      end
      vectors++;
      if (bus.i2c_stop !== exp_stop || bus.i2c_start !== exp_start) begin
        errors++; $display("FAIL strobe_byte%0d: stop=%b start=%b expected %b,%b", k, bus.i2c_stop, bus.i2c_start, exp_stop, exp_start);
      end
      @(negedge clk);
      if (k == nack_at) begin
        code   = (k == 0 || (rw && k == 2)) ? 1 : 2;
        nacked = 1'b1;
        break;
      end
    end

    if (rw && !nacked) begin
      for (int j = 0; j < elen; j++) begin
        if (j == abort_rd) begin
          quiet();
          rst = 1'b1;
          @(negedge clk); #1;
          vectors++;
          if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
              bus.i2c_start !== 1'b0 || bus.i2c_stop !== 1'b0 || bus.i2c_wr_data !== 8'h00 || bus.err_code !== 2'd0) begin
            errors++; $display("FAIL abort_outputs: ready=%b busy=%b done=%b start=%b stop=%b wd=%02h code=%0d expected 1,0,0,0,0,00,0",
              bus.cmd_ready, bus.busy, bus.done, bus.i2c_start, bus.i2c_stop, bus.i2c_wr_data, bus.err_code);
          end
          for (int i = 0; i < NB; i++) begin
            bus.buf_rd_idx = 3'(i); #1;
            vectors++;
            if (bus.buf_rd_data !== 8'h00) begin
              errors++; $display("FAIL abort_rbuf%0d: got %02h expected 00", i, bus.buf_rd_data);
            end
            wmodel[i] = 8'h00;
            rmodel[i] = 8'h00;
          end
          rst = 1'b0;
          @(negedge clk);
          return;
        end
        repeat ($urandom_range(0, 2)) begin
          noise(1'b1); #1;
          vectors++;
          if (bus.i2c_stop !== 1'b0 || bus.done !== 1'b0) begin
            errors++; $display("FAIL idle_rd%0d: stop=%b done=%b expected 0,0", j, bus.i2c_stop, bus.done);
          end
          @(negedge clk);
        end
        noise(1'b1);
        d = rd_fixed ? rd_src[j] : 8'($urandom);
        bus.i2c_rd_tick = 1'b1;
        bus.i2c_rd_data = d;
        rmodel[j] = d;
        #1;
        vectors++;
        if (bus.i2c_stop !== (j == elen - 1)) begin
          errors++; $display("FAIL rd_stop%0d: got %b expected %b", j, bus.i2c_stop, (j == elen - 1));
        end
        @(negedge clk);
      end
    end

    quiet(); #1;
    vectors++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b1 || bus.err !== (code != 0) || bus.err_code !== 2'(code)) begin
      errors++; $display("FAIL completion: done=%b busy=%b err=%b code=%0d expected 1,1,%b,%0d",
        bus.done, bus.busy, bus.err, bus.err_code, (code != 0), code);
    end
    if (rw && elen == 0) begin
      vectors++;
      if (bus.i2c_start !== 1'b0) begin
        errors++; $display("FAIL rlen0_start: got %b expected 0", bus.i2c_start);
      end
    end
    @(negedge clk); #1;
    vectors++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL back_to_idle: done=%b busy=%b ready=%b expected 0,0,1", bus.done, bus.busy, bus.cmd_ready);
    end
    for (int i = 0; i < NB; i++) begin
      bus.buf_rd_idx = 3'(i); #1;
      vectors++;
      if (bus.buf_rd_data !== rmodel[i]) begin
        errors++; $display("FAIL rbuf%0d: got %02h expected %02h", i, bus.buf_rd_data, rmodel[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    quiet();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0 ||
        bus.err_code !== 2'd0 || bus.i2c_start !== 1'b0 || bus.i2c_stop !== 1'b0 || bus.i2c_wr_data !== 8'h00) begin
      errors++; $display("FAIL reset_outputs: ready=%b busy=%b done=%b err=%b code=%0d start=%b stop=%b wd=%02h expected 1,0,0,0,0,0,0,00",
        bus.cmd_ready, bus.busy, bus.done, bus.err, bus.err_code, bus.i2c_start, bus.i2c_stop, bus.i2c_wr_data);
    end
    for (int i = 0; i < NB; i++) begin
      bus.buf_rd_idx = 3'(i); #1;
      vectors++;
      if (bus.buf_rd_data !== 8'h00) begin
        errors++; $display("FAIL reset_rbuf%0d: got %02h expected 00", i, bus.buf_rd_data);
      end
      wmodel[i] = 8'h00;
      rmodel[i] = 8'h00;
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_spec_write();
    logic [7:0] pat [NB] = '{8'h00, 8'h40, 8'h50, 8'h03, 8'h28, 8'h07, 8'h21, 8'h00};
    for (int i = 0; i < NB; i++) begin
      quiet();
      bus.buf_wr_en   = 1'b1;
      bus.buf_wr_idx  = 3'(i);
      bus.buf_wr_data = pat[i];
      wmodel[i] = pat[i];
      @(negedge clk);
    end
    run_cmd(1'b0, 8'h00, 4'd8, -1, -1, 1'b0);
  endtask

  task automatic test_spec_read();
    logic [7:0] src [NB] = '{8'h12, 8'h34, 8'h56, 8'h01, 8'h28, 8'h07, 8'h21, 8'h00};
    for (int i = 0; i < NB; i++) rd_src[i] = src[i];
    rd_fixed = 1'b1;
    run_cmd(1'b1, 8'h00, 4'd7, -1, -1, 1'b0);
    rd_fixed = 1'b0;
  endtask

  task automatic test_nacks();
    run_cmd(1'b0, 8'h10, 4'd4, 0, -1, 1'b0);
    run_cmd(1'b0, 8'h05, 4'd3, 3, -1, 1'b0);
    run_cmd(1'b1, 8'h22, 4'd5, 2, -1, 1'b0);
    run_cmd(1'b1, 8'h22, 4'd5, 1, -1, 1'b0);
  endtask

  task automatic test_len_edges();
    run_cmd(1'b1, 8'h03, 4'd0, -1, -1, 1'b0);
    run_cmd(1'b0, 8'h03, 4'd0, -1, -1, 1'b0);
    run_cmd(1'b0, 8'h01, 4'd15, -1, -1, 1'b1);
    run_cmd(1'b1, 8'h01, 4'd12, -1, -1, 1'b1);
    run_cmd(1'b1, 8'h02, 4'd1, -1, -1, 1'b1);
  endtask

  task automatic test_random();
    bit rw;
    logic [3:0] len;
    int elen, nbytes, nack_at;
    for (int n = 0; n < 40; n++) begin
      rw      = 1'($urandom);
      len     = 4'($urandom);
      elen    = (len > 4'(NB)) ? NB : int'(len);
      nbytes  = rw ? 3 : 2 + elen;
      nack_at = (!(rw && elen == 0) && ($urandom_range(0, 2) == 0)) ? $urandom_range(0, nbytes - 1) : -1;
      run_cmd(rw, 8'($urandom), len, nack_at, -1, 1'b1);
    end
  endtask

  task automatic test_reset_mid_rdat();
    run_cmd(1'b1, 8'h00, 4'd7, -1, 3, 1'b1);
    run_cmd(1'b0, 8'h09, 4'd2, -1, -1, 1'b0);
  endtask

  initial begin
    quiet();
    bus.buf_rd_idx = 3'd0;
    test_reset();
    test_spec_write();
    test_spec_read();
    test_nacks();
    test_len_edges();
    test_random();
    test_reset_mid_rdat();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
